// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, LSB-first serialisation with start/stop framing.
// Optional even-parity bit after the data bits is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int unsigned N            = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Valid,
  input  logic [N-1:0] Data,
  output logic         Ready,
  output logic         Busy,
  output logic         Tx
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(N + STOP_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [CW-1:0]  bit_q, bit_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic           baud_term;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  assign baud_term = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (Valid) begin
          shreg_d = Data;
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^Data;
`endif
        end
      end
      START: begin
        if (baud_term) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_term) begin
          baud_d = '0;
          if (bit_q == CW'(N - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // The next data bit is bit 0 of the freshly shifted register.
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_d[0];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_term) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_term) begin
          baud_d = '0;
          // Bit counter is reused to count stop bits.
          if (bit_q == CW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Ready = (state_q == IDLE) && !Reset;
  assign Busy  = (state_q != IDLE);
  assign Tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed, table-driven bench for uart_tx at CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
  localparam int NV = 7;
`else
  localparam int FL = 10;
  localparam int NV = 5;
`endif
  localparam int L = FL * C;

  typedef logic [0:FL-1] seq_t;
  typedef struct {
    logic [7:0] data;
    seq_t       seq;
  } vec_t;

  logic       Clk, Reset, Valid, Ready, Busy, Tx;
  logic [7:0] Data;

  int checks   = 0;
  int failures = 0;
  vec_t vecs [NV];

  uart_tx #(.N(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .Data(Data),
    .Ready(Ready), .Busy(Busy), .Tx(Tx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, Tx, 1'b1);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_ready"}, Ready, 1'b1);
  endtask

  // Called just after the acceptance edge; ends in the first IDLE cycle.
  task automatic check_frame(input logic [7:0] d, input seq_t seq);
    for (int k = 0; k < L; k++) begin
      chk($sformatf("tx d=%0h k=%0d", d, k), Tx, seq[k / C]);
      chk($sformatf("busy d=%0h k=%0d", d, k), Busy, 1'b1);
      chk($sformatf("ready d=%0h k=%0d", d, k), Ready, 1'b0);
      tick();
    end
    chk_idle($sformatf("end d=%0h", d));
  endtask

  task automatic send(input logic [7:0] d, input seq_t seq);
    int n = 0;
    while (!Ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", Ready, 1'b1);
    Valid = 1'b1;
    Data  = d;
    tick();
    Valid = 1'b0;
    Data  = 8'($urandom);
    check_frame(d, seq);
  endtask

  initial begin
    // Time-ordered line bits: start, d0..d7, [parity], stop.
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 11'b0_10101010_0_1};
    vecs[1] = '{8'hA3, 11'b0_11000101_0_1};
    vecs[2] = '{8'h00, 11'b0_00000000_0_1};
    vecs[3] = '{8'hFF, 11'b0_11111111_0_1};
    vecs[4] = '{8'h0F, 11'b0_11110000_0_1};
    vecs[5] = '{8'h07, 11'b0_11100000_1_1};
    vecs[6] = '{8'h03, 11'b0_11000000_0_1};
`else
    vecs[0] = '{8'h55, 10'b0_10101010_1};
    vecs[1] = '{8'hA3, 10'b0_11000101_1};
    vecs[2] = '{8'h00, 10'b0_00000000_1};
    vecs[3] = '{8'hFF, 10'b0_11111111_1};
    vecs[4] = '{8'h0F, 10'b0_11110000_1};
`endif

    Reset = 1'b1;
    Valid = 1'b0;
    Data  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_tx", Tx, 1'b1);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_ready", Ready, 1'b0);
    end
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_idle("post_rst");
      tick();
    end

    for (int v = 0; v < NV; v++) begin
      send(vecs[v].data, vecs[v].seq);
      tick();
    end

    // Valid held through the frame with Data changed mid-frame, then back-to-back frames.
    Valid = 1'b1;
    Data  = 8'hA3;
    tick();
    Data  = 8'h00;
    check_frame(8'hA3, vecs[1].seq);
    tick();
    check_frame(8'h00, vecs[2].seq);
    Data = 8'hFF;
    tick();
    Valid = 1'b0;
    check_frame(8'hFF, vecs[3].seq);
    tick();
    chk_idle("after_ff");

    // Reset during data bit 3 of 0x0F.
    Valid = 1'b1;
    Data  = 8'h0F;
    tick();
    Valid = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    chk("pre_rst_busy", Busy, 1'b1);
    chk("pre_rst_tx", Tx, 1'b1);
    Reset = 1'b1;
    tick();
    chk("midrst_tx", Tx, 1'b1);
    chk("midrst_busy", Busy, 1'b0);
    Reset = 1'b0;
    Valid = 1'b1;
    Data  = 8'h55;
    #1;
    chk("midrst_ready", Ready, 1'b1);
    tick();
    Valid = 1'b0;
    check_frame(8'h55, vecs[0].seq);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
